// File: rtl/sort_sched_pkg.sv
// Shared types and default sizes for the sort/unique engine scheduler.
package sort_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam int NREQ_DEF    = 4;
    localparam int ID_W        = $clog2(NREQ_DEF);
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sort_unique_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         gnt_next,
    output logic [$clog2(NREQ)-1:0] id_next,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        int idx;
        idx      = 0;
        gnt_next = '0;
        id_next  = '0;
        any      = 1'b0;
        // rr_ptr itself is searched last, so the previous winner yields to everyone else
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any           = 1'b1;
                gnt_next[idx] = 1'b1;
                id_next       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sort_unique_sched.sv
// Round-robin scheduler sharing one sort/unique engine among NREQ requesters.
// Optional RUN-phase abort when SCHED_TIMEOUT_EN is defined.
module sort_unique_sched #(
    parameter int NREQ    = sort_sched_pkg::NREQ_DEF,
    parameter int CNT_W   = sort_sched_pkg::CNT_W,
    parameter int TIMEOUT = sort_sched_pkg::TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    eng_ld,
    output logic                    eng_en,
    input  logic                    eng_done,
    input  logic [CNT_W-1:0]        eng_count,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [CNT_W-1:0]        rsp_count,
    output logic                    rsp_err
);

    import sort_sched_pkg::*;

    localparam int IW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     id_q, id_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_id;
    logic              arb_any;
    logic              tmo_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .gnt_next (arb_gnt),
        .id_next  (arb_id),
        .any      (arb_any)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmo_q, tmo_d;

    // Held at zero outside RUN, so it is already clear on RUN entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_RUN) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    id_d    = arb_id;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                // done takes precedence over a same-cycle timeout
                if (eng_done) begin
                    cnt_d   = eng_count;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = id_q;
                    gnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign eng_ld    = (state_q == S_LOAD);
    assign eng_en    = (state_q == S_RUN);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_count = cnt_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_sort_unique_sched.sv
// Scoreboard bench for sort_unique_sched; timeout scenario runs when SCHED_TIMEOUT_EN is defined.
module tb_sort_unique_sched;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;
`ifdef SCHED_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    logic             clk, rst;
    logic [NREQ-1:0]  req, gnt;
    logic             busy, eng_ld, eng_en, eng_done;
    logic [CNT_W-1:0] eng_count, rsp_count;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [1:0]       rsp_id;

    sort_unique_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .busy      (busy),
        .eng_ld    (eng_ld),
        .eng_en    (eng_en),
        .eng_done  (eng_done),
        .eng_count (eng_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   passed = 0;
    int   ld_pulses = 0;
    exp_t sb[$];
    exp_t mon_e;

    bit         eng_auto = 1'b1;
    int         eng_delay = 0;
    logic [7:0] eng_val = 8'd0;
    int         run_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond(input int w);
        case (w)
            0:       return eng_en;
            1:       return eng_ld;
            2:       return rsp_valid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm);
        int n;
        n = 0;
        while (!cond(which) && n < 200) begin
            tick();
            n++;
        end
        check({"wait_", nm}, 32'(cond(which)), 32'd1);
    endtask

    // Engine model: raises eng_done during the eng_delay-th RUN cycle (0 = never).
    initial forever begin
        @(posedge clk);
        #1;
        if (eng_auto) begin
            if (eng_en) begin
                run_cnt++;
                eng_done = (eng_delay != 0 && run_cnt == eng_delay);
            end else begin
                run_cnt  = 0;
                eng_done = 1'b0;
            end
            eng_count = eng_val;
        end
    end

    always @(negedge clk) begin
        if (eng_ld) ld_pulses++;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got response id=%0d count=%0d, none expected", rsp_id, rsp_count);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id",    32'(rsp_id),    32'(mon_e.id));
                check("rsp_count", 32'(rsp_count), 32'(mon_e.cnt));
                check("rsp_err",   32'(rsp_err),   32'(mon_e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld0;
        int run;
        rst = 1'b1; req = '0; rsp_ready = 1'b1; eng_done = 1'b0; eng_count = '0;
        repeat (3) tick();
        check("rst_gnt",       32'(gnt),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_eng_ld",    32'(eng_ld),    32'd0);
        check("rst_eng_en",    32'(eng_en),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_count", 32'(rsp_count), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        rst = 1'b0;
        tick();

        // reset in the middle of RUN
        eng_delay = 0; req = 4'b0001;
        wait_for(0, "t1_run");
        repeat (2) tick();
        rst = 1'b1; req = '0;
        tick();
        check("t1_rst_gnt",   32'(gnt),       32'd0);
        check("t1_rst_busy",  32'(busy),      32'd0);
        check("t1_rst_en",    32'(eng_en),    32'd0);
        check("t1_rst_ld",    32'(eng_ld),    32'd0);
        check("t1_rst_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0; req = 4'b0001; eng_delay = 2; eng_val = 8'd7;
        sb.push_back(exp_t'{2'd0, 8'd7, 1'b0});
        tick();
        check("t1_ld_latency", 32'(eng_ld), 32'd1);
        check("t1_gnt",        32'(gnt),    32'b0001);
        req = '0;
        wait_for(3, "t1_idle");

        // fairness with all requesters held
        rst = 1'b1;
        tick();
        rst = 1'b0; eng_delay = 3; eng_val = 8'd9;
        sb.push_back(exp_t'{2'd0, 8'd9, 1'b0});
        sb.push_back(exp_t'{2'd1, 8'd9, 1'b0});
        sb.push_back(exp_t'{2'd2, 8'd9, 1'b0});
        sb.push_back(exp_t'{2'd3, 8'd9, 1'b0});
        sb.push_back(exp_t'{2'd0, 8'd9, 1'b0});
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_for(1, "t2_ld");
            if (j == 4) req = '0;
            tick();
        end
        wait_for(3, "t2_idle");
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // back-pressure: response held stable, single load pulse
        rsp_ready = 1'b0; eng_delay = 2; eng_val = 8'd5;
        sb.push_back(exp_t'{2'd2, 8'd5, 1'b0});
        ld0 = ld_pulses;
        req = 4'b0100;
        wait_for(2, "t3_valid");
        for (int k = 0; k < 4; k++) begin
            check("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check("t3_hold_id",    32'(rsp_id),    32'd2);
            check("t3_hold_count", 32'(rsp_count), 32'd5);
            check("t3_hold_err",   32'(rsp_err),   32'd0);
            tick();
        end
        rsp_ready = 1'b1; req = '0;
        tick();
        check("t3_after_busy",  32'(busy),      32'd0);
        check("t3_after_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("t3_ld_pulses", 32'(ld_pulses - ld0), 32'd1);

        // requester withdraws during RUN
        eng_delay = 4; eng_val = 8'd11;
        sb.push_back(exp_t'{2'd1, 8'd11, 1'b0});
        req = 4'b0010;
        wait_for(0, "t4_run");
        req = '0;
        wait_for(3, "t4_idle");
        check("t4_gnt",        32'(gnt),      32'd0);
        check("t4_busy",       32'(busy),     32'd0);
        check("t4_sb_drained", 32'(sb.size()), 32'd0);

        // eng_done during LOAD must not end the job
        eng_auto = 1'b0; eng_done = 1'b0;
        req = 4'b0001;
        wait_for(1, "t6_load");
        eng_done = 1'b1; eng_count = 8'd99;
        tick();
        eng_done = 1'b0;
        check("t6_run_entered", 32'(eng_en), 32'd1);
        repeat (2) tick();
        check("t6_still_run",  32'(eng_en),    32'd1);
        check("t6_no_rsp",     32'(rsp_valid), 32'd0);
        eng_count = 8'd6; eng_done = 1'b1; req = '0;
        sb.push_back(exp_t'{2'd0, 8'd6, 1'b0});
        tick();
        eng_done = 1'b0;
        check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_for(3, "t6_idle");
        eng_auto = 1'b1;

`ifdef SCHED_TIMEOUT_EN
        // abort after TIMEOUT RUN cycles, then done on the last cycle wins
        eng_delay = 0; eng_val = 8'hAA;
        sb.push_back(exp_t'{2'd1, 8'd0, 1'b1});
        req = 4'b0010;
        wait_for(0, "t5_run");
        run = 0;
        while (eng_en && run < 40) begin
            run++;
            tick();
        end
        check("t5_run_cycles", 32'(run),       32'd16);
        check("t5_valid",      32'(rsp_valid), 32'd1);
        check("t5_err",        32'(rsp_err),   32'd1);
        req = '0;
        wait_for(3, "t5_idle");

        eng_delay = 16; eng_val = 8'd4;
        sb.push_back(exp_t'{2'd1, 8'd4, 1'b0});
        req = 4'b0010;
        wait_for(0, "t5b_run");
        run = 0;
        while (eng_en && run < 40) begin
            run++;
            tick();
        end
        check("t5b_run_cycles", 32'(run),     32'd16);
        check("t5b_err",        32'(rsp_err), 32'd0);
        req = '0;
        wait_for(3, "t5b_idle");
`endif

        repeat (3) tick();
        check("final_sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
